// File: rtl/tdc_meas_ctrl.sv
// Burst sequencer for a TDC: launch/gap/capture strobes, result accumulation with timeout.
// Optional min/max sample tracking is enabled by defining TDC_MEAS_MINMAX_EN.
module tdc_meas_ctrl #(
  parameter int HW_W    = 7,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      cfg_samples,
  input  logic [3:0]      cfg_gap,
  output logic            clk_launch,
  output logic            clk_capture,
  output logic            pg_in,
  output logic            val_in,
  input  logic [HW_W-1:0] hw,
  input  logic            val_out,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [14:0]     res_sum,
  output logic [8:0]      res_cnt,
`ifdef TDC_MEAS_MINMAX_EN
  output logic            res_err,
  output logic [HW_W-1:0] res_min,
  output logic [HW_W-1:0] res_max
`else
  output logic            res_err
`endif
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, GAP, CAPTURE, WAIT, DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     gapCfg_q, gapCfg_d;
  logic [3:0]     gapCnt_q, gapCnt_d;
  logic [WCW-1:0] waitCnt_q, waitCnt_d;
  logic [8:0]     remain_q, remain_d;
  logic [14:0]    sum_q, sum_d;
  logic [8:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           launch_q, capture_q, pg_q, busy_q, valid_q;
  logic [14:0]    hwExt, hwClamp;
  logic           leaveWait;
`ifdef TDC_MEAS_MINMAX_EN
  logic [HW_W-1:0] min_q, min_d, max_q, max_d;
`endif

  always_comb begin
    hwExt   = 15'(hw);
    hwClamp = (hwExt > 15'd64) ? 15'd64 : hwExt;
  end

  always_comb begin
    state_d   = state_q;
    gapCfg_d  = gapCfg_q;
    gapCnt_d  = gapCnt_q;
    waitCnt_d = waitCnt_q;
    remain_d  = remain_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    leaveWait = 1'b0;
`ifdef TDC_MEAS_MINMAX_EN
    min_d = min_q;
    max_d = max_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          gapCfg_d = cfg_gap;
          remain_d = (cfg_samples == 8'd0) ? 9'd256 : {1'b0, cfg_samples};
          sum_d    = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
`ifdef TDC_MEAS_MINMAX_EN
          min_d = HW_W'(127);
          max_d = '0;
`endif
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        gapCnt_d = '0;
        state_d  = (gapCfg_q != 4'd0) ? GAP : CAPTURE;
      end
      GAP: begin
        if (gapCnt_q == gapCfg_q - 4'd1) state_d = CAPTURE;
        else gapCnt_d = gapCnt_q + 4'd1;
      end
      CAPTURE: begin
        waitCnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        // A result arriving in the last allowed cycle still wins over the timeout.
        if (val_out) begin
          sum_d     = sum_q + hwClamp;
          cnt_d     = cnt_q + 9'd1;
          leaveWait = 1'b1;
`ifdef TDC_MEAS_MINMAX_EN
          if (HW_W'(hwClamp) < min_q) min_d = HW_W'(hwClamp);
          if (HW_W'(hwClamp) > max_q) max_d = HW_W'(hwClamp);
`endif
        end else if (waitCnt_q == WCW'(TIMEOUT - 1)) begin
          err_d     = 1'b1;
          leaveWait = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
        if (leaveWait) begin
          remain_d = remain_q - 9'd1;
          state_d  = (remain_q == 9'd1) ? DONE : LAUNCH;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gapCfg_q  <= '0;
      gapCnt_q  <= '0;
      waitCnt_q <= '0;
      remain_q  <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      launch_q  <= 1'b0;
      capture_q <= 1'b0;
      pg_q      <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gapCfg_q  <= gapCfg_d;
      gapCnt_q  <= gapCnt_d;
      waitCnt_q <= waitCnt_d;
      remain_q  <= remain_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      launch_q  <= (state_d == LAUNCH);
      capture_q <= (state_d == CAPTURE);
      pg_q      <= pg_q ^ (state_d == LAUNCH);
      busy_q    <= (state_d != IDLE);
      valid_q   <= (state_d == DONE);
    end
  end

`ifdef TDC_MEAS_MINMAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= HW_W'(127);
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign res_min = min_q;
  assign res_max = max_q;
`endif

  assign clk_launch  = launch_q;
  assign clk_capture = capture_q;
  assign val_in      = capture_q;
  assign pg_in       = pg_q;
  assign busy        = busy_q;
  assign res_valid   = valid_q;
  assign res_sum     = sum_q;
  assign res_cnt     = cnt_q;
  assign res_err     = err_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed, table-driven bench for tdc_meas_ctrl; min/max checks run when TDC_MEAS_MINMAX_EN is defined.
module tb_tdc_meas_ctrl;

  localparam int HW_W   = 7;
  localparam int BUDGET = 2000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [7:0]      cfg_samples;
  logic [3:0]      cfg_gap;
  logic            clk_launch, clk_capture, pg_in, val_in;
  logic [HW_W-1:0] hw;
  logic            val_out;
  logic            busy, res_valid, res_ready;
  logic [14:0]     res_sum;
  logic [8:0]      res_cnt;
  logic            res_err;
`ifdef TDC_MEAS_MINMAX_EN
  logic [HW_W-1:0] res_min, res_max;
`endif

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  tdc_meas_ctrl #(.HW_W(HW_W), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_samples(cfg_samples), .cfg_gap(cfg_gap),
    .clk_launch(clk_launch), .clk_capture(clk_capture), .pg_in(pg_in), .val_in(val_in),
    .hw(hw), .val_out(val_out), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_cnt(res_cnt),
`ifdef TDC_MEAS_MINMAX_EN
    .res_err(res_err), .res_min(res_min), .res_max(res_max)
`else
    .res_err(res_err)
`endif
  );

  // delay = cycles from the capture cycle to the val_out cycle; 0 means never respond.
  typedef struct {
    int samples; int gap; int hwVal; int delay; bit holdStart;
    int expSum; int expCnt; int expErr; int expLaunch; int expCycles;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_launch"}, clk_launch, 0);
    checkOutput({tag, "_capture"}, clk_capture, 0);
    checkOutput({tag, "_valin"}, val_in, 0);
    checkOutput({tag, "_pg"}, pg_in, 0);
    checkOutput({tag, "_valid"}, res_valid, 0);
    checkOutput({tag, "_sum"}, res_sum, 0);
    checkOutput({tag, "_cnt"}, res_cnt, 0);
    checkOutput({tag, "_err"}, res_err, 0);
  endtask

  // Called at a negedge; start is applied for the very next rising edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    int firstLaunch, firstCap, doneCyc, sinceCap, launches, pgToggles, valinBad, stableBad;
    logic prevPg;
    logic [14:0] heldSum;
    cfg_samples = 8'(v.samples);
    cfg_gap     = 4'(v.gap);
    hw          = HW_W'(v.hwVal);
    start       = 1'b1;
    res_ready   = 1'b0;
    val_out     = 1'b0;
    prevPg      = pg_in;
    firstLaunch = -1; firstCap = -1; doneCyc = -1; sinceCap = -1;
    launches = 0; pgToggles = 0; valinBad = 0; stableBad = 0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      if (cyc == 0) checkOutput({tag, "_busyAfterStart"}, busy, 1);
      start = v.holdStart;
      if (v.holdStart) begin
        cfg_samples = 8'd9;
        cfg_gap     = 4'd7;
      end
      if (res_valid) begin
        doneCyc = cyc;
        start   = 1'b0;
        val_out = 1'b0;
        break;
      end
      if (clk_launch) begin
        launches++;
        if (firstLaunch < 0) firstLaunch = cyc;
        if (pg_in != prevPg) pgToggles++;
      end
      prevPg = pg_in;
      if (clk_capture) begin
        if (firstCap < 0) firstCap = cyc;
        sinceCap = 0;
      end else if (sinceCap >= 0) begin
        sinceCap++;
      end
      if (val_in != clk_capture) valinBad++;
      val_out = (v.delay != 0) && (sinceCap == v.delay);
    end
    if (doneCyc < 0) begin
      checkOutput({tag, "_doneReached"}, 0, 1);
      rst_n = 1'b0;
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    checkOutput({tag, "_sum"}, res_sum, v.expSum);
    checkOutput({tag, "_cnt"}, res_cnt, v.expCnt);
    checkOutput({tag, "_err"}, res_err, v.expErr);
    checkOutput({tag, "_launches"}, launches, v.expLaunch);
    checkOutput({tag, "_pgToggles"}, pgToggles, v.expLaunch);
    checkOutput({tag, "_valinBad"}, valinBad, 0);
    checkOutput({tag, "_firstLaunch"}, firstLaunch, 0);
    checkOutput({tag, "_span"}, firstCap - firstLaunch, v.gap + 1);
    checkOutput({tag, "_cycles"}, doneCyc - firstLaunch, v.expCycles);
    heldSum = res_sum;
    repeat (3) begin
      @(negedge clk);
      if (!res_valid || res_sum != heldSum) stableBad++;
    end
    checkOutput({tag, "_doneStable"}, stableBad, 0);
    res_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_idleBusy"}, busy, 0);
    checkOutput({tag, "_idleValid"}, res_valid, 0);
    start     = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_startInDoneIgnored"}, busy, 0);
  endtask

  initial begin
    vec_t cleanVec;
    vecs[0] = '{4,   0, 10,  1,  1'b0, 40,    4,   0, 4,   12};
    vecs[1] = '{2,   3, 100, 1,  1'b0, 128,   2,   0, 2,   12};
    vecs[2] = '{2,   0, 10,  0,  1'b0, 0,     0,   1, 2,   34};
    vecs[3] = '{0,   0, 64,  1,  1'b0, 16384, 256, 0, 256, 768};
    vecs[4] = '{0,   1, 100, 2,  1'b0, 16384, 256, 0, 256, 1280};
    vecs[5] = '{3,   2, 0,   1,  1'b1, 0,     3,   0, 3,   15};
    vecs[6] = '{1,   15, 63, 3,  1'b0, 63,    1,   0, 1,   20};
    vecs[7] = '{2,   0, 7,   15, 1'b0, 14,    2,   0, 2,   34};
    vecs[8] = '{2,   0, 7,   16, 1'b0, 0,     0,   1, 2,   34};
    vecs[9] = '{1,   0, 65,  1,  1'b0, 64,    1,   0, 1,   3};

    rst_n = 1'b0; start = 1'b0; cfg_samples = '0; cfg_gap = '0;
    hw = '0; val_out = 1'b0; res_ready = 1'b0;
    #3;
    checkIdleZero("reset");
`ifdef TDC_MEAS_MINMAX_EN
    checkOutput("reset_min", res_min, 127);
    checkOutput("reset_max", res_max, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a gap, then a clean burst straight after release.
    cfg_samples = 8'd3; cfg_gap = 4'd15; hw = 7'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("midGap_launch", clk_launch, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("midGap_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkIdleZero("midGapReset");
    @(negedge clk);
    rst_n = 1'b1;
    cleanVec = '{2, 1, 9, 1, 1'b0, 18, 2, 0, 2, 8};
    applyStimulus(cleanVec, "afterReset");

`ifdef TDC_MEAS_MINMAX_EN
    begin
      int seq[3];
      int k;
      int sinceCap;
      bit seen;
      seq[0] = 5; seq[1] = 20; seq[2] = 12;
      k = 0; sinceCap = -1; seen = 1'b0;
      cfg_samples = 8'd3; cfg_gap = 4'd0; hw = 7'd5; start = 1'b1;
      for (int cyc = 0; cyc < BUDGET; cyc++) begin
        @(negedge clk);
        start = 1'b0;
        if (res_valid) begin
          seen = 1'b1;
          break;
        end
        if (clk_capture) begin
          hw = HW_W'(seq[k]);
          k++;
          sinceCap = 0;
        end else if (sinceCap >= 0) begin
          sinceCap++;
        end
        val_out = (sinceCap == 1);
      end
      val_out = 1'b0;
      checkOutput("minmax_done", seen, 1);
      checkOutput("minmax_min", res_min, 5);
      checkOutput("minmax_max", res_max, 20);
      checkOutput("minmax_sum", res_sum, 37);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
